// File: rtl/fifo_arbiter.sv
// Host-interface data FIFO controller: owns pointers/count of a single-port RAM and
// round-robins it between ADMA writes and SD reads. Define FIFO_ARB_ALMOST_EN for almost flags.
module fifo_arbiter #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 32,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  flush,
  input  logic                  wr_req,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  wr_ack,
  input  logic                  rd_req,
  output logic                  rd_ack,
  output logic                  rd_valid,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
`ifdef FIFO_ARB_ALMOST_EN
  ,
  output logic                  almost_full,
  output logic                  almost_empty
`endif
);

  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);

  typedef enum logic {WIN_READ = 1'b0, WIN_WRITE = 1'b1} win_e;

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   cnt_q;
  win_e                  last_win;
  logic                  w_elig;
  logic                  r_elig;
  logic                  grant_wr;
  logic                  grant_rd;

  assign full  = (cnt_q == DEPTH_CNT);
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

  // Handshake: a request is held by the requester; the ack in the same cycle means the
  // word moved at the coming edge. Un-acked requests simply retry next cycle.
  assign w_elig   = wr_req & ~full  & ~flush & ~RESET;
  assign r_elig   = rd_req & ~empty & ~flush & ~RESET;
  assign grant_wr = w_elig & (~r_elig | (last_win == WIN_READ));
  assign grant_rd = r_elig & ~grant_wr;

  assign wr_ack    = grant_wr;
  assign rd_ack    = grant_rd;
  assign mem_en    = grant_wr | grant_rd;
  assign mem_we    = grant_wr;
  assign mem_wdata = grant_wr ? wr_data : '0;
  assign rd_data   = mem_rdata;

  always_comb begin
    mem_addr = '0;
    if (grant_wr)      mem_addr = wr_ptr;
    else if (grant_rd) mem_addr = rd_ptr;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt_q     <= '0;
      last_win  <= WIN_READ;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // A read granted the cycle before a flush still delivers its word.
      rd_valid <= grant_rd;
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        cnt_q     <= '0;
        last_win  <= WIN_READ;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (wr_req & full)  overflow  <= 1'b1;
        if (rd_req & empty) underflow <= 1'b1;
        if (grant_wr) begin
          wr_ptr <= wr_ptr + 1'b1;
          cnt_q  <= cnt_q + 1'b1;
        end else if (grant_rd) begin
          rd_ptr <= rd_ptr + 1'b1;
          cnt_q  <= cnt_q - 1'b1;
        end
        if (w_elig & r_elig) last_win <= grant_wr ? WIN_WRITE : WIN_READ;
      end
    end
  end

`ifdef FIFO_ARB_ALMOST_EN
  localparam logic [DEPTH_LOG2:0] AF_CNT = AF_LEVEL[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] AE_CNT = AE_LEVEL[DEPTH_LOG2:0];
  assign almost_full  = (cnt_q >= AF_CNT);
  assign almost_empty = (cnt_q <= AE_CNT);
`endif

endmodule

// File: tb/tb_fifo_arbiter.sv
// Randomized and directed bench for fifo_arbiter against a queue-based reference model,
// with a behavioural single-port RAM hanging off the mem_* port.
module tb_fifo_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        flush;
  logic        wr_req;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic        rd_req;
  logic        rd_ack;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        underflow;
`ifdef FIFO_ARB_ALMOST_EN
  logic        almost_full;
  logic        almost_empty;
`endif

  fifo_arbiter #(.DEPTH_LOG2(4), .DATA_W(32), .AF_LEVEL(12), .AE_LEVEL(4)) dut (
    .CLK(CLK), .RESET(RESET), .flush(flush),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .count(count), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow)
`ifdef FIFO_ARB_ALMOST_EN
    , .almost_full(almost_full), .almost_empty(almost_empty)
`endif
  );

  // clock / RAM
  always #5 CLK = ~CLK;

  logic [31:0] ram [16];
  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // reference model
  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  bit          m_rd_valid;
  bit          m_ovf;
  bit          m_udf;
  bit          m_wr_turn;
  int          m_wr_idx;
  int          m_rd_idx;
  int          n_checks;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    fifo_q.delete();
    exp_q.delete();
    m_rd_valid = 0;
    m_ovf      = 0;
    m_udf      = 0;
    m_wr_turn  = 1;
    m_wr_idx   = 0;
    m_rd_idx   = 0;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic cycle(input bit wr, input logic [31:0] data, input bit rd, input bit fl);
    bit w, r, gw, gr, is_full, is_empty;
    wr_req  = wr;
    wr_data = data;
    rd_req  = rd;
    flush   = fl;
    #3;
    is_full  = (fifo_q.size() == 16);
    is_empty = (fifo_q.size() == 0);
    check("count", 32'(count), 32'(fifo_q.size()));
    check("full", 32'(full), 32'(is_full));
    check("empty", 32'(empty), 32'(is_empty));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_udf));
    check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
    if (m_rd_valid && exp_q.size() > 0) check("rd_data", rd_data, exp_q.pop_front());
    w  = wr && !is_full && !fl;
    r  = rd && !is_empty && !fl;
    gw = w && (!r || m_wr_turn);
    gr = r && !gw;
    check("wr_ack", 32'(wr_ack), 32'(gw));
    check("rd_ack", 32'(rd_ack), 32'(gr));
    check("mem_en", 32'(mem_en), 32'(gw || gr));
    check("mem_we", 32'(mem_we), 32'(gw));
    check("mem_addr", 32'(mem_addr), gw ? 32'(m_wr_idx % 16) : gr ? 32'(m_rd_idx % 16) : 32'd0);
    check("mem_wdata", mem_wdata, gw ? data : 32'd0);
    m_rd_valid = gr;
    if (fl) begin
      fifo_q.delete();
      m_ovf     = 0;
      m_udf     = 0;
      m_wr_turn = 1;
      m_wr_idx  = 0;
      m_rd_idx  = 0;
    end else begin
      if (wr && is_full)  m_ovf = 1;
      if (rd && is_empty) m_udf = 1;
      if (w && r) m_wr_turn = gr;
      if (gw) begin
        fifo_q.push_back(data);
        m_wr_idx++;
      end
      if (gr) begin
        exp_q.push_back(fifo_q.pop_front());
        m_rd_idx++;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  // Asynchronous reset pulse mid-cycle, with a write request held to show acks stay low.
  task automatic reset_pulse();
    wr_req  = 1'b1;
    wr_data = 32'hdead_beef;
    rd_req  = 1'b1;
    flush   = 1'b0;
    #1;
    RESET = 1'b1;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_wr_ack", 32'(wr_ack), 32'd0);
    check("rst_rd_ack", 32'(rd_ack), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    model_reset();
    wr_req = 1'b0;
    rd_req = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RESET   = 1'b1;
    flush   = 1'b0;
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    wr_data = '0;
    model_reset();
    @(posedge CLK);
    #1;
    reset_pulse();

    // reset mid-stream: 7 stored, one read in flight
    for (int i = 0; i < 8; i++) cycle(1, $urandom, 0, 0);
    cycle(0, 0, 1, 0);
    reset_pulse();

    // fill with 1..16, then one write too many
    for (int i = 1; i <= 17; i++) cycle(1, 32'(i), 0, 0);
    // drain past empty
    for (int i = 0; i < 17; i++) cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);

    // contention from 8 words: W,R,W,R,W,R
    for (int i = 1; i <= 8; i++) cycle(1, 32'(100 + i), 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 32'(200 + i), 1, 0);
    cycle(0, 0, 0, 1);

    // order preserved across pointer wrap
    for (int i = 1; i <= 10; i++) cycle(1, 32'(i), 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0);
    for (int i = 11; i <= 20; i++) cycle(1, 32'(i), 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);

    // flush with both requests pending at count 5
    for (int i = 0; i < 5; i++) cycle(1, $urandom, 0, 0);
    cycle(1, $urandom, 1, 1);
    cycle(0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            $urandom_range(0, 40) == 0);
    cycle(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_arbiter.md
# fifo_arbiter

Controller and arbiter for the 32-bit host-interface data FIFO used on the ADMA path. It owns the read/write pointers and occupancy count of a single-port FIFO RAM. Each cycle it grants that RAM to either the ADMA write side or the SD-card read side, using round-robin priority when both request. It also reports full/empty/count and sticky overflow/underflow errors to the ADMA engine.

## Interface
- DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 16 words)
- DATA_W, 32, data word width
- AF_LEVEL, 12, almost-full threshold (used only with FIFO_ARB_ALMOST_EN)
- AE_LEVEL, 4, almost-empty threshold (used only with FIFO_ARB_ALMOST_EN)

- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of pointers, count and errors
- wr_req  in  1  ADMA side requests a word write
- wr_data  in  DATA_W  word to write
- wr_ack  out  1  write granted this cycle (combinational)
- rd_req  in  1  SD side requests a word read
- rd_ack  out  1  read granted this cycle (combinational)
- rd_valid  out  1  rd_data valid (registered, one cycle after rd_ack)
- rd_data  out  DATA_W  read word, equals mem_rdata while rd_valid
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  DEPTH_LOG2  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, one-cycle synchronous latency
- count  out  DEPTH_LOG2+1  words stored, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky: wr_req seen while full
- underflow  out  1  sticky: rd_req seen while empty
- almost_full, almost_empty  out  1  present only with FIFO_ARB_ALMOST_EN

## Operation
- Eligibility: W = wr_req & !full & !flush; R = rd_req & !empty & !flush.
- Grant: W only -> write; R only -> read; both -> the side not granted at the last contended cycle (register last_win, reset = READ, so the first contention goes to write). last_win updates only on contended cycles.
- Write grant: mem_en=1, mem_we=1, mem_addr=wr_ptr, mem_wdata=wr_data, wr_ack=1. At the edge, wr_ptr+1 and count+1.
- Read grant: mem_en=1, mem_we=0, mem_addr=rd_ptr, rd_ack=1. At the edge, rd_ptr+1, count-1, rd_valid<=1.
- No grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- At most one RAM access per cycle, so count changes by at most ±1. Pointers wrap modulo DEPTH.
- Errors: overflow sets on any cycle with wr_req & full. underflow sets on any cycle with rd_req & empty. Both clear only on flush or RESET.
- Flush: no grants in the flush cycle. At the edge, wr_ptr=rd_ptr=0, count=0, errors=0, last_win=READ. rd_valid follows normally, so a read granted in the prior cycle still returns its data.
- RESET (any time, including mid-read): wr_ptr, rd_ptr, count, last_win=READ, rd_valid, overflow and underflow all clear immediately. Resulting outputs: empty=1, full=0, count=0, rd_valid=0, rd_data=mem_rdata (don't-care), all acks and mem strobes 0. RAM contents are not cleared.

## Timing
- Write latency: data is stored at the edge ending the wr_ack cycle. full, empty and count reflect it in the next cycle.
- Read latency: rd_ack in cycle N, rd_valid=1 with data in cycle N+1. Back-to-back reads give one word per cycle.
- Write to empty FIFO at edge N: the earliest read grant is in cycle N+1, with data valid in N+2.
- full/empty/count are registered-state decodes and never depend combinationally on the requests. wr_ack and rd_ack do depend combinationally on the requests.

## Configuration
- FIFO_ARB_ALMOST_EN defined: almost_full = (count >= AF_LEVEL), almost_empty = (count <= AE_LEVEL), both decoded from the registered count.
- Not defined: the almost_full and almost_empty ports and their logic are absent. All other behaviour is identical.

## Test plan
- RESET pulse mid-stream with count=7 -> count=0, empty=1, full=0, rd_valid=0, overflow=underflow=0 immediately.
- 16 writes of 1..16, rd_req=0 -> 16 wr_ack, full=1 after the 16th edge. 17th wr_req -> no wr_ack, overflow=1.
- From full, rd_req held for 17 cycles -> rd_data 1..16 in order on consecutive rd_valid cycles, empty=1, then underflow=1.
- Preload 8 words, then wr_req and rd_req held together for 6 cycles -> grants W,R,W,R,W,R; count oscillates 9,8,9,8,9,8.
- Write 10, read 10, write 10, read 10 (values 1..20) -> output order 1..20 intact across pointer wrap at 16.
- count=5 with wr_req and rd_req asserted, then flush=1 for one cycle -> no acks in that cycle, count=0, empty=1, errors cleared.
